// File: rtl/uart_mmio_if.sv
// rtl/uart_mmio_if.sv - register bus between the interconnect and the UART peripheral
// Purpose: groups the address-qualified strobes, address, write data, read data and interrupt.
// Signals:
//   we     register write strobe (already address-qualified)
//   re     register read strobe (already address-qualified)
//   addr   register byte offset
//   wdata  write data
//   rdata  read data, combinational from addr
//   irq    level interrupt request
// Modports: master = interconnect / CPU side, slave = peripheral side.
interface uart_mmio_if #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 8
);
  logic                 we;
  logic                 re;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] rdata;
  logic                 irq;

  modport master (output we, output re, output addr, output wdata, input rdata, input irq);
  modport slave  (input we, input re, input addr, input wdata, output rdata, output irq);
endinterface

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped 8N1 UART with TX shifter, RX sampler, RX FIFO and level irq
// Purpose: CPU-bus UART peripheral. Registers (byte offsets, addr[1:0] ignored):
//   0x00 TXDATA W, 0x04 RXDATA R (pop on re), 0x08 STATUS R/W1C,
//   0x0C BAUD_DIV RW (min 4), 0x10 IRQ_EN RW; other offsets read 0.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      register bus (slave modport): we, re, addr, wdata -> rdata, irq
//   uart_tx  serial out, idle high
//   uart_rx  serial in, asynchronous to clk
module uart_mmio #(
  parameter int DATA_BITS     = 32,
  parameter int ADDR_BITS     = 8,
  parameter int CLK_DIV_RESET = 868,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  uart_mmio_if.slave  bus,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int PW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- register decode ----------------
  logic [ADDR_BITS-3:0] reg_idx;
  logic sel_tx, sel_rx, sel_status, sel_baud, sel_irqen;

  assign reg_idx    = bus.addr[ADDR_BITS-1:2];
  assign sel_tx     = (reg_idx == (ADDR_BITS-2)'(0));
  assign sel_rx     = (reg_idx == (ADDR_BITS-2)'(1));
  assign sel_status = (reg_idx == (ADDR_BITS-2)'(2));
  assign sel_baud   = (reg_idx == (ADDR_BITS-2)'(3));
  assign sel_irqen  = (reg_idx == (ADDR_BITS-2)'(4));

  logic unused_bits;
  assign unused_bits = ^{bus.wdata[DATA_BITS-1:16], bus.addr[1:0]};

  logic [15:0] baud_div;
  logic [2:0]  irq_en;
  logic        ovr, ferr, irq_q;

  // ---------------- TX path ----------------
  state_t      tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line_n;
  logic        tx_ready, wr_tx;

  assign tx_ready = (tx_state == S_IDLE);
  assign wr_tx    = bus.we & sel_tx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
    end
  end

  // Each state holds for tx_cnt clocks; the counter reloads from baud_div
  // only at a bit boundary, so a rate change never splits a bit.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = uart_tx;
    case (tx_state)
      S_IDLE: begin
        tx_line_n = 1'b1;
        if (wr_tx) begin
          tx_state_n = S_START;
          tx_cnt_n   = baud_div;
          tx_shift_n = bus.wdata[7:0];
          tx_line_n  = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt == 16'd1) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = baud_div;
          tx_bit_n   = 3'd0;
          tx_line_n  = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt == 16'd1) begin
          tx_cnt_n = baud_div;
          if (tx_bit == 3'd7) begin
            tx_state_n = S_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt == 16'd1) begin
          tx_state_n = S_IDLE;
        end else begin
          tx_cnt_n = tx_cnt - 16'd1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic        rx_s1, rx_s2, rx_prev;
  state_t      rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_push, rx_ferr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // The start bit is checked half a bit after the falling edge; every
  // later sample is a whole bit apart, landing near bit centres.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = S_START;
          rx_cnt_n   = baud_div >> 1;
        end
      end
      S_START: begin
        if (rx_cnt == 16'd1) begin
          if (rx_s2) begin
            rx_state_n = S_IDLE;
          end else begin
            rx_state_n = S_DATA;
            rx_cnt_n   = baud_div;
            rx_bit_n   = 3'd0;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt == 16'd1) begin
          rx_cnt_n   = baud_div;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = S_STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt == 16'd1) begin
          rx_state_n  = S_IDLE;
          rx_push     = rx_s2;
          rx_ferr_set = !rx_s2;
        end else begin
          rx_cnt_n = rx_cnt - 16'd1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, pop, push_ok, ovr_set;

  assign fifo_full  = (count == CW'(RX_FIFO_DEPTH));
  assign fifo_empty = (count == CW'(0));
  assign pop        = bus.re & sel_rx & !fifo_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok    = rx_push & (!fifo_full | pop);
  assign ovr_set    = rx_push & fifo_full & !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr] <= rx_shift;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- control registers, flags, irq ----------------
  logic wr_status, wr_baud, wr_irqen;

  assign wr_status = bus.we & sel_status;
  assign wr_baud   = bus.we & sel_baud;
  assign wr_irqen  = bus.we & sel_irqen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_div <= 16'(CLK_DIV_RESET);
      irq_en   <= 3'd0;
      ovr      <= 1'b0;
      ferr     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_baud) begin
        baud_div <= (bus.wdata[15:0] < 16'd4) ? 16'd4 : bus.wdata[15:0];
      end
      if (wr_irqen) begin
        irq_en <= bus.wdata[2:0];
      end
      // Setting on the same edge as a write-1-clear keeps the flag.
      ovr   <= ovr_set     | (ovr  & !(wr_status & bus.wdata[3]));
      ferr  <= rx_ferr_set | (ferr & !(wr_status & bus.wdata[4]));
      irq_q <= (irq_en[0] & !fifo_empty) |
               (irq_en[1] & tx_ready) |
               (irq_en[2] & (ovr | ferr));
    end
  end

  assign bus.irq = irq_q;

  logic [DATA_BITS-1:0] rd;

  always_comb begin
    rd = '0;
    if (sel_rx) begin
      if (fifo_empty) rd[31] = 1'b1;
      else            rd[7:0] = fifo_mem[rptr];
    end else if (sel_status) begin
      rd[4:0] = {ferr, ovr, fifo_full, !fifo_empty, tx_ready};
    end else if (sel_baud) begin
      rd[15:0] = baud_div;
    end else if (sel_irqen) begin
      rd[2:0] = irq_en;
    end
  end

  assign bus.rdata = rd;

endmodule
